// File: rtl/multi_cycle_controller.sv
// Main control FSM for the multi-cycle RV32I core: sequences fetch/decode/execute/memory/writeback.
// Latency: 2..5 cycles per instruction (lw 5, sw/R/I/jal 4, beq 3, illegal 2); outputs valid every cycle.
// Backpressure: none; memory is single-cycle and the FSM advances on every rising edge.
//
// Ports:
//   i_clk, i_arst          core clock, asynchronous active-high reset (forces FETCH immediately)
//   i_opcode               instruction_q[6:0], sampled only in DECODE and MEMADR
//   i_zeroFlag             ALU zero flag, qualifies the PC write in BEQ
//   o_pcWrite/o_irWrite/o_regWrite/o_memWrite   state-element enables
//   o_adrSrc/o_resultSrc/o_aluSrcA/o_aluSrcB/o_aluOp   datapath mux selects and ALU steering
//   o_retire               one-cycle pulse in the last state of each legal instruction
//   o_illegal              one-cycle pulse in DECODE for an unsupported opcode
module multi_cycle_controller (
    input  logic       i_clk,
    input  logic       i_arst,
    input  logic [6:0] i_opcode,
    input  logic       i_zeroFlag,
    output logic       o_pcWrite,
    output logic       o_adrSrc,
    output logic       o_memWrite,
    output logic       o_irWrite,
    output logic [1:0] o_resultSrc,
    output logic [1:0] o_aluSrcA,
    output logic [1:0] o_aluSrcB,
    output logic [1:0] o_aluOp,
    output logic       o_regWrite,
    output logic       o_retire,
    output logic       o_illegal
);

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECUTER = 4'd6,
        S_EXECUTEI = 4'd7,
        S_ALUWB    = 4'd8,
        S_JAL      = 4'd9,
        S_BEQ      = 4'd10
    } state_t;

    // Registered copy of the Moore decode. pc_update and branch are kept
    // separate so the BEQ PC write can be qualified by the live zero flag.
    typedef struct packed {
        logic       pc_update;
        logic       branch;
        logic       adr_src;
        logic       mem_write;
        logic       ir_write;
        logic [1:0] result_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic       reg_write;
        logic       retire;
    } ctrl_t;

    state_t state_q, state_d;
    ctrl_t  ctrl_q, ctrl_d;
    logic   opcode_legal;
    logic   state_valid;

    // Per-state control decode; anything not listed stays 0.
    function automatic ctrl_t ctrl_for(input state_t s);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH: begin
                c.adr_src    = 1'b0;
                c.ir_write   = 1'b1;
                c.alu_src_a  = 2'b00;
                c.alu_src_b  = 2'b10;
                c.alu_op     = 2'b00;
                c.result_src = 2'b10;
                c.pc_update  = 1'b1;
            end
            S_DECODE: begin
                // oldPc + imm lands in the ALU output register as the branch/jump target
                c.alu_src_a = 2'b01;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b00;
            end
            S_MEMADR: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b00;
            end
            S_MEMREAD: begin
                c.result_src = 2'b00;
                c.adr_src    = 1'b1;
            end
            S_MEMWB: begin
                c.result_src = 2'b01;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_MEMWRITE: begin
                c.result_src = 2'b00;
                c.adr_src    = 1'b1;
                c.mem_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_EXECUTER: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b00;
                c.alu_op    = 2'b10;
            end
            S_EXECUTEI: begin
                c.alu_src_a = 2'b10;
                c.alu_src_b = 2'b01;
                c.alu_op    = 2'b10;
            end
            S_ALUWB: begin
                c.result_src = 2'b00;
                c.reg_write  = 1'b1;
                c.retire     = 1'b1;
            end
            S_JAL: begin
                // oldPc + 4 is the link value; the PC takes the DECODE target
                c.alu_src_a  = 2'b01;
                c.alu_src_b  = 2'b10;
                c.alu_op     = 2'b00;
                c.result_src = 2'b00;
                c.pc_update  = 1'b1;
            end
            S_BEQ: begin
                c.alu_src_a  = 2'b10;
                c.alu_src_b  = 2'b00;
                c.alu_op     = 2'b01;
                c.result_src = 2'b00;
                c.branch     = 1'b1;
                c.retire     = 1'b1;
            end
            default: c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        opcode_legal = 1'b0;
        case (i_opcode)
            OP_LW, OP_SW, OP_RTYPE, OP_ITYPE, OP_JAL, OP_BEQ: opcode_legal = 1'b1;
            default:                                          opcode_legal = 1'b0;
        endcase
    end

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                case (i_opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXECUTER;
                    OP_ITYPE:     state_d = S_EXECUTEI;
                    OP_JAL:       state_d = S_JAL;
                    OP_BEQ:       state_d = S_BEQ;
                    default:      state_d = S_FETCH;
                endcase
            end
            // Only lw and sw reach MEMADR, so the store opcode alone picks the path.
            S_MEMADR:   state_d = (i_opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
            S_MEMREAD:  state_d = S_MEMWB;
            S_EXECUTER: state_d = S_ALUWB;
            S_EXECUTEI: state_d = S_ALUWB;
            S_JAL:      state_d = S_ALUWB;
            S_MEMWB, S_MEMWRITE, S_ALUWB, S_BEQ: state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // Decoding the next state lets the outputs come straight from flops.
    always_comb begin
        ctrl_d = '0;
        ctrl_d = ctrl_for(state_d);
    end

    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q <= S_FETCH;
            ctrl_q  <= ctrl_for(S_FETCH);
        end else begin
            state_q <= state_d;
            ctrl_q  <= ctrl_d;
        end
    end

    // An upset into an unused encoding must not leave stale enables driving
    // the datapath; mask everything until the FSM recovers to FETCH.
    always_comb begin
        state_valid = 1'b0;
        case (state_q)
            S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB, S_MEMWRITE,
            S_EXECUTER, S_EXECUTEI, S_ALUWB, S_JAL, S_BEQ: state_valid = 1'b1;
            default:                                       state_valid = 1'b0;
        endcase
    end

    assign o_pcWrite   = state_valid & (ctrl_q.pc_update | (ctrl_q.branch & i_zeroFlag));
    assign o_adrSrc    = state_valid & ctrl_q.adr_src;
    assign o_memWrite  = state_valid & ctrl_q.mem_write;
    assign o_irWrite   = state_valid & ctrl_q.ir_write;
    assign o_resultSrc = ctrl_q.result_src & {2{state_valid}};
    assign o_aluSrcA   = ctrl_q.alu_src_a & {2{state_valid}};
    assign o_aluSrcB   = ctrl_q.alu_src_b & {2{state_valid}};
    assign o_aluOp     = ctrl_q.alu_op & {2{state_valid}};
    assign o_regWrite  = state_valid & ctrl_q.reg_write;
    assign o_retire    = state_valid & ctrl_q.retire;
    // The IR is stable throughout DECODE, so this is a clean one-cycle pulse.
    assign o_illegal   = (state_q == S_DECODE) & ~opcode_legal;

endmodule

// File: tb/tb_multi_cycle_controller.sv
module tb_multi_cycle_controller;

    logic       clk;
    logic       arst;
    logic [6:0] opcode;
    logic       zero;
    logic       pc_write, adr_src, mem_write, ir_write, reg_write, retire, illegal;
    logic [1:0] result_src, alu_src_a, alu_src_b, alu_op;

    int checks;
    int failures;

    multi_cycle_controller dut (
        .i_clk      (clk),
        .i_arst     (arst),
        .i_opcode   (opcode),
        .i_zeroFlag (zero),
        .o_pcWrite  (pc_write),
        .o_adrSrc   (adr_src),
        .o_memWrite (mem_write),
        .o_irWrite  (ir_write),
        .o_resultSrc(result_src),
        .o_aluSrcA  (alu_src_a),
        .o_aluSrcB  (alu_src_b),
        .o_aluOp    (alu_op),
        .o_regWrite (reg_write),
        .o_retire   (retire),
        .o_illegal  (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // {pcWrite, adrSrc, memWrite, irWrite, resultSrc, aluSrcA, aluSrcB, aluOp, regWrite, retire, illegal}
    logic [14:0] obs;
    assign obs = {pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
                  alu_src_b, alu_op, reg_write, retire, illegal};

    localparam logic [6:0] LW = 7'b0000011, SW = 7'b0100011, RT = 7'b0110011;
    localparam logic [6:0] IT = 7'b0010011, JAL = 7'b1101111, BEQ = 7'b1100011;

    function automatic logic [14:0] mk(input logic pcw, input logic adr, input logic mw,
                                       input logic ir, input logic [1:0] rs, input logic [1:0] a,
                                       input logic [1:0] b, input logic [1:0] op, input logic rw,
                                       input logic ret, input logic ill);
        return {pcw, adr, mw, ir, rs, a, b, op, rw, ret, ill};
    endfunction

    function automatic bit is_legal(input logic [6:0] op);
        return (op == LW) || (op == SW) || (op == RT) || (op == IT) || (op == JAL) || (op == BEQ);
    endfunction

    // Instruction length in cycles, FETCH through retire state.
    function automatic int n_cycles(input logic [6:0] op);
        if (op == LW) return 5;
        if (op == BEQ) return 3;
        if (is_legal(op)) return 4;
        return 2;
    endfunction

    // Expected output word for cycle c (1-based) of an instruction with opcode op.
    function automatic logic [14:0] expect_out(input logic [6:0] op, input int c, input logic z);
        logic [14:0] fetch_v, wb_v;
        fetch_v = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        wb_v    = mk(0, 0, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        if (c == 1) return fetch_v;
        if (c == 2) return mk(0, 0, 0, 0, 2'b00, 2'b01, 2'b01, 2'b00, 0, 0, !is_legal(op));
        if (op == LW) begin
            if (c == 3) return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
            if (c == 4) return mk(0, 1, 0, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 0, 0);
            return mk(0, 0, 0, 0, 2'b01, 2'b00, 2'b00, 2'b00, 1, 1, 0);
        end
        if (op == SW) begin
            if (c == 3) return mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b00, 0, 0, 0);
            return mk(0, 1, 1, 0, 2'b00, 2'b00, 2'b00, 2'b00, 0, 1, 0);
        end
        if (op == RT) return (c == 3) ? mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b10, 0, 0, 0) : wb_v;
        if (op == IT) return (c == 3) ? mk(0, 0, 0, 0, 2'b00, 2'b10, 2'b01, 2'b10, 0, 0, 0) : wb_v;
        if (op == JAL) return (c == 3) ? mk(1, 0, 0, 0, 2'b00, 2'b01, 2'b10, 2'b00, 0, 0, 0) : wb_v;
        return mk(z, 0, 0, 0, 2'b00, 2'b10, 2'b00, 2'b01, 0, 1, 0);
    endfunction

    // Caller is in the low phase of a FETCH cycle on entry and exit.
    task automatic test_reset();
        logic [14:0] fetch_v;
        fetch_v = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        arst = 1'b0; opcode = RT; zero = 1'b0;
        #3 arst = 1'b1;
        #1;
        checks++;
        if (obs !== fetch_v) begin
            failures++;
            $display("FAIL reset_async got=%h exp=%h", obs, fetch_v);
        end
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (obs !== fetch_v) begin
            failures++;
            $display("FAIL reset_hold got=%h exp=%h", obs, fetch_v);
        end
        @(negedge clk);
        arst = 1'b0;
        for (int c = 1; c <= n_cycles(RT); c++) begin
            #1;
            checks++;
            if (obs !== expect_out(RT, c, zero)) begin
                failures++;
                $display("FAIL reset_first_instr cyc=%0d got=%h exp=%h", c, obs, expect_out(RT, c, zero));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_instr(input string name, input logic [6:0] op, input logic z);
        opcode = op;
        for (int c = 1; c <= n_cycles(op); c++) begin
            zero = z;
            #1;
            checks++;
            if (obs !== expect_out(op, c, z)) begin
                failures++;
                $display("FAIL %s cyc=%0d got=%h exp=%h", name, c, obs, expect_out(op, c, z));
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset_mid_lw();
        logic [14:0] fetch_v;
        fetch_v = mk(1, 0, 0, 1, 2'b10, 2'b00, 2'b10, 2'b00, 0, 0, 0);
        opcode = LW;
        repeat (3) @(negedge clk);   // now in MEMREAD
        #1;
        checks++;
        if (obs !== expect_out(LW, 4, zero)) begin
            failures++;
            $display("FAIL mid_reset_memread got=%h exp=%h", obs, expect_out(LW, 4, zero));
        end
        #1 arst = 1'b1;
        #1;
        checks++;
        if (obs !== fetch_v || reg_write !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_abort got=%h exp=%h", obs, fetch_v);
        end
        @(posedge clk);
        #1;
        checks++;
        if (reg_write !== 1'b0 || mem_write !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset_no_write got=%b%b exp=00", reg_write, mem_write);
        end
        @(negedge clk);
        arst = 1'b0;
        test_instr("after_mid_reset", SW, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0] pool [6];
        logic [6:0] op;
        pool[0] = LW; pool[1] = SW; pool[2] = RT; pool[3] = IT; pool[4] = JAL; pool[5] = BEQ;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 6) == 0) begin
                do op = 7'($urandom); while (is_legal(op));
            end else begin
                op = pool[$urandom_range(0, 5)];
            end
            opcode = op;
            for (int c = 1; c <= n_cycles(op); c++) begin
                zero = 1'($urandom);
                #1;
                checks++;
                if (obs !== expect_out(op, c, zero)) begin
                    failures++;
                    $display("FAIL random op=%b cyc=%0d got=%h exp=%h", op, c, obs, expect_out(op, c, zero));
                end
                @(negedge clk);
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        arst = 1'b0;
        opcode = 7'd0;
        zero = 1'b0;
        test_reset();
        test_instr("lw", LW, 1'b0);
        test_instr("sw", SW, 1'b1);
        test_instr("rtype", RT, 1'b1);
        test_instr("beq_taken", BEQ, 1'b1);
        test_instr("beq_not_taken", BEQ, 1'b0);
        test_instr("itype", IT, 1'b0);
        test_instr("jal", JAL, 1'b0);
        test_instr("illegal", 7'b1110011, 1'b0);
        test_instr("after_illegal", RT, 1'b0);
        test_reset_mid_lw();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
